// File: rtl/bp_resolve_queue.sv
// Resolved-branch buffer feeding the predictor's 2-bit counter update port,
// with misprediction flagging and saturating branch/mispredict statistics.
module bp_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [7:0]       res_pc,
    input  logic             res_taken,
    input  logic             res_pred,
    input  logic             upd_hold,
    output logic             upd_we,
    output logic [7:0]       upd_addr,
    output logic             upd_taken,
    output logic             mispredict,
    output logic [7:0]       mispredict_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [7:0]       memAddr_q  [DEPTH];
    logic             memTaken_q [DEPTH];
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW:0]      count_q, count_d;
    logic             mispredict_q, mispredict_d;
    logic [7:0]       mispredictPc_q, mispredictPc_d;
    logic [CNT_W-1:0] brCount_q, brCount_d;
    logic [CNT_W-1:0] mpCount_q, mpCount_d;
    logic             push, pop, isMiss;

    // A full queue refuses pushes even when the head is leaving this cycle.
    assign res_ready = (count_q != FULL_CNT);
    assign upd_we    = (count_q != '0) && !upd_hold;
    assign upd_addr  = memAddr_q[rdPtr_q];
    assign upd_taken = memTaken_q[rdPtr_q];

    assign push   = res_valid && res_ready;
    assign pop    = upd_we;
    assign isMiss = res_taken != res_pred;

    assign mispredict    = mispredict_q;
    assign mispredict_pc = mispredictPc_q;
    assign br_count      = brCount_q;
    assign mp_count      = mpCount_q;

    always_comb begin
        rdPtr_d        = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
        wrPtr_d        = push ? wrPtr_q + PW'(1) : wrPtr_q;
        count_d        = count_q;
        if (push && !pop)
            count_d = count_q + (PW+1)'(1);
        else if (pop && !push)
            count_d = count_q - (PW+1)'(1);
        mispredict_d   = push && isMiss;
        mispredictPc_d = mispredict_d ? res_pc : mispredictPc_q;
        brCount_d      = (push && brCount_q != '1) ? brCount_q + CNT_W'(1) : brCount_q;
        mpCount_d      = (push && isMiss && mpCount_q != '1) ? mpCount_q + CNT_W'(1) : mpCount_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr_q        <= '0;
            wrPtr_q        <= '0;
            count_q        <= '0;
            mispredict_q   <= 1'b0;
            mispredictPc_q <= '0;
            brCount_q      <= '0;
            mpCount_q      <= '0;
        end else begin
            rdPtr_q        <= rdPtr_d;
            wrPtr_q        <= wrPtr_d;
            count_q        <= count_d;
            mispredict_q   <= mispredict_d;
            mispredictPc_q <= mispredictPc_d;
            brCount_q      <= brCount_d;
            mpCount_q      <= mpCount_d;
        end
    end

    // Storage holds no reset; stale entries are never visible while upd_we is low.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            memAddr_q[wrPtr_q]  <= res_pc;
            memTaken_q[wrPtr_q] <= res_taken;
        end
    end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Self-checking bench for bp_resolve_queue: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_bp_resolve_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_pc;
    logic             res_taken;
    logic             res_pred;
    logic             upd_hold;
    logic             upd_we;
    logic [7:0]       upd_addr;
    logic             upd_taken;
    logic             mispredict;
    logic [7:0]       mispredict_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state
    logic [8:0] mdlQ[$];
    bit         mdlValid = 0;
    int         mdlBr, mdlMp;
    bit         mdlMiss;
    logic [7:0] mdlMissPc;

    bp_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_taken(res_taken), .res_pred(res_pred),
        .upd_hold(upd_hold), .upd_we(upd_we), .upd_addr(upd_addr), .upd_taken(upd_taken),
        .mispredict(mispredict), .mispredict_pc(mispredict_pc),
        .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, checks outputs against the model, then clocks.
    task automatic applyStimulus(input logic v, input logic [7:0] pc, input logic t,
                                 input logic p, input logic h, input logic r);
        bit expReady, expWe, doPush;
        res_valid = v; res_pc = pc; res_taken = t; res_pred = p; upd_hold = h; rst = r;
        #1;
        expReady = (mdlQ.size() != DEPTH);
        expWe    = (mdlQ.size() != 0) && !h;
        if (mdlValid) begin
            checkOutput("res_ready", int'(res_ready), int'(expReady));
            checkOutput("upd_we", int'(upd_we), int'(expWe));
            if (expWe) begin
                checkOutput("upd_addr", int'(upd_addr), int'(mdlQ[0][8:1]));
                checkOutput("upd_taken", int'(upd_taken), int'(mdlQ[0][0]));
            end
            checkOutput("mispredict", int'(mispredict), int'(mdlMiss));
            checkOutput("mispredict_pc", int'(mispredict_pc), int'(mdlMissPc));
            checkOutput("br_count", int'(br_count), mdlBr);
            checkOutput("mp_count", int'(mp_count), mdlMp);
        end
        if (r) begin
            mdlQ.delete();
            mdlBr = 0; mdlMp = 0; mdlMiss = 0; mdlMissPc = '0;
            mdlValid = 1;
        end else begin
            doPush = v && expReady;
            if (expWe) void'(mdlQ.pop_front());
            mdlMiss = doPush && (t != p);
            if (doPush) begin
                mdlQ.push_back({pc, t});
                if (mdlBr < MAXC) mdlBr++;
                if (t != p) begin
                    mdlMissPc = pc;
                    if (mdlMp < MAXC) mdlMp++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, h, 1'b0);
    endtask

    initial begin
        rst = 1'b1; res_valid = 0; res_pc = 0; res_taken = 0; res_pred = 0; upd_hold = 0;
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_ready", int'(res_ready), 1);
        checkOutput("reset_we", int'(upd_we), 0);

        // Single mispredicted branch into an empty queue
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("single_we", int'(upd_we), 1);
        checkOutput("single_addr", int'(upd_addr), 8'h3C);
        checkOutput("single_mp", int'(mispredict), 1);
        idle(2, 1'b0);

        // Fill under hold: fifth offer refused until the first pop
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 8'(8'h10 + i), 1'(i % 2), 1'(i % 2), 1'b1, 1'b0);
        checkOutput("fill_ready", int'(res_ready), 0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Back-to-back streaming with correct predictions
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 8'(8'h40 + i), 1'(i % 3 == 0), 1'(i % 3 == 0), 1'b0, 1'b0);
        idle(2, 1'b0);

        // Full queue with a simultaneous pop and push offer
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 8'(8'h60 + i), 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h70, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h70, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6, 1'b0);

        // Counter saturation
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        checkOutput("sat_br", int'(br_count), MAXC);
        checkOutput("sat_mp", int'(mp_count), MAXC);

        // Mid-operation reset with three entries queued
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_mid_we", int'(upd_we), 0);
        checkOutput("rst_mid_pc", int'(mispredict_pc), 0);
        applyStimulus(1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++)
            applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom),
                          1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 79) == 0));
        idle(8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
